// File: rtl/alu_pkg.sv
// Shared opcode constants, the entry-sequence state type and the opcode
// validity helper for the ALU operand sequencer.
package alu_pkg;

  localparam int unsigned DATA_W = 4;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_MUL = 5'd2;
  localparam logic [4:0] OP_DIV = 5'd3;
  localparam logic [4:0] OP_MOD = 5'd4;
  localparam logic [4:0] OP_AND = 5'd5;
  localparam logic [4:0] OP_OR  = 5'd6;
  localparam logic [4:0] OP_XOR = 5'd7;
  localparam logic [4:0] OP_SLL = 5'd8;
  localparam logic [4:0] OP_SRL = 5'd9;
  localparam logic [4:0] OP_MAX = OP_SRL;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } seq_state_t;

  function automatic logic op_valid(input logic [4:0] op);
    return (op <= OP_MAX);
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser plus rising-edge detector for a raw push button.
// A button already held when reset is released is ignored until it has been seen low.
module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic       r_meta;
  logic       r_sync;
  logic       r_prev;
  logic       r_armed;
  logic [1:0] r_fill;

  // r_fill marks when r_sync reflects the button; arming needs a released level after that
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_prev  <= 1'b0;
      r_fill  <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_meta  <= i_btn;
      r_sync  <= r_meta;
      r_prev  <= r_sync;
      r_fill  <= {r_fill[0], 1'b1};
      r_armed <= r_armed | (r_fill[1] & ~r_sync);
    end
  end

  assign o_pulse = r_sync & ~r_prev & r_armed;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Step-by-step operand/opcode entry front-end for the lab ALU: captures A, B and
// a validated opcode from switches, then holds the ALU result and flags for display.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned N = DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sw,
  input  logic [4:0]   op_sw,
  input  logic         load_btn,
  input  logic         clr_btn,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [4:0]   alu_ctrl,
  input  logic [N-1:0] alu_q,
  input  logic [4:0]   alu_f,
  output logic [N-1:0] res_q,
  output logic [4:0]   res_f,
  output logic [2:0]   step,
  output logic         err,
  output logic         done
);

  logic       w_load_p;
  logic       w_clr_p;
  seq_state_t r_state;
  seq_state_t w_state_nxt;
  logic       w_cap_a;
  logic       w_cap_b;
  logic       w_cap_op;
  logic       w_op_rej;
  logic       w_cap_res;
  logic       w_clr_flags;
  logic       w_done_clr;

  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic [4:0]   r_ctrl;
  logic [N-1:0] r_res_q;
  logic [4:0]   r_res_f;
  logic         r_err;
  logic         r_done;

  btn_sync u_load_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (load_btn),
    .o_pulse (w_load_p)
  );

  btn_sync u_clr_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (clr_btn),
    .o_pulse (w_clr_p)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_A;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and capture strobes; abort wins over a coincident load
  always_comb begin
    w_state_nxt = r_state;
    w_cap_a     = 1'b0;
    w_cap_b     = 1'b0;
    w_cap_op    = 1'b0;
    w_op_rej    = 1'b0;
    w_cap_res   = 1'b0;
    w_clr_flags = 1'b0;
    w_done_clr  = 1'b0;
    if (w_clr_p) begin
      w_state_nxt = S_A;
      w_clr_flags = 1'b1;
    end else begin
      case (r_state)
        S_A: begin
          if (w_load_p) begin
            w_cap_a     = 1'b1;
            w_state_nxt = S_B;
          end else begin
            w_state_nxt = S_A;
          end
        end
        S_B: begin
          if (w_load_p) begin
            w_cap_b     = 1'b1;
            w_state_nxt = S_OP;
          end else begin
            w_state_nxt = S_B;
          end
        end
        S_OP: begin
          if (w_load_p && op_valid(op_sw)) begin
            w_cap_op    = 1'b1;
            w_state_nxt = S_EXEC;
          end else if (w_load_p) begin
            w_op_rej    = 1'b1;
            w_state_nxt = S_OP;
          end else begin
            w_state_nxt = S_OP;
          end
        end
        S_EXEC: begin
          w_cap_res   = 1'b1;
          w_state_nxt = S_SHOW;
        end
        S_SHOW: begin
          if (w_load_p) begin
            w_done_clr  = 1'b1;
            w_state_nxt = S_A;
          end else begin
            w_state_nxt = S_SHOW;
          end
        end
        default: begin
          w_state_nxt = S_A;
        end
      endcase
    end
  end

  // Operand, opcode, result and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_ctrl  <= 5'd0;
      r_res_q <= '0;
      r_res_f <= 5'd0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_cap_a) begin
        r_a <= sw;
      end
      if (w_cap_b) begin
        r_b <= sw;
      end
      if (w_cap_op) begin
        r_ctrl <= op_sw;
      end
      if (w_cap_res) begin
        r_res_q <= alu_q;
        r_res_f <= alu_f;
      end
      if (w_clr_flags || w_cap_op) begin
        r_err <= 1'b0;
      end else if (w_op_rej) begin
        r_err <= 1'b1;
      end
      if (w_clr_flags || w_done_clr) begin
        r_done <= 1'b0;
      end else if (w_cap_res) begin
        r_done <= 1'b1;
      end
    end
  end

  assign alu_a    = r_a;
  assign alu_b    = r_b;
  assign alu_ctrl = r_ctrl;
  assign res_q    = r_res_q;
  assign res_f    = r_res_f;
  assign step     = r_state;
  assign err      = r_err;
  assign done     = r_done;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Randomised and directed bench for alu_operand_sequencer against an
// event-level model of the entry sequence, with a behavioural 4-bit ALU attached.
module tb_alu_operand_sequencer;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw;
  logic [4:0] op_sw;
  logic       load_btn;
  logic       clr_btn;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [4:0] alu_ctrl;
  logic [3:0] alu_q;
  logic [4:0] alu_f;
  logic [3:0] res_q;
  logic [4:0] res_f;
  logic [2:0] step;
  logic       err;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  // model state: entry step 0..4 and the values the outputs should hold
  int         m_st;
  logic [3:0] m_a, m_b, m_q;
  logic [4:0] m_ctrl, m_f;
  logic       m_err, m_done;

  alu_operand_sequencer #(.N(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .op_sw    (op_sw),
    .load_btn (load_btn),
    .clr_btn  (clr_btn),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_ctrl (alu_ctrl),
    .alu_q    (alu_q),
    .alu_f    (alu_f),
    .res_q    (res_q),
    .res_f    (res_f),
    .step     (step),
    .err      (err),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags: {div_by_zero, overflow, negative, zero, carry}
  function automatic logic [8:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [4:0] op);
    logic [4:0] s;
    logic [3:0] q;
    logic c, v, dz;
    c = 1'b0; v = 1'b0; dz = 1'b0; s = 5'd0;
    case (op)
      5'd0: begin s = {1'b0, a} + {1'b0, b}; q = s[3:0]; c = s[4]; v = (a[3] == b[3]) && (q[3] != a[3]); end
      5'd1: begin s = {1'b0, a} - {1'b0, b}; q = s[3:0]; c = s[4]; v = (a[3] != b[3]) && (q[3] != a[3]); end
      5'd2: q = 4'(a * b);
      5'd3: begin if (b == 4'd0) begin q = 4'hF; dz = 1'b1; end else q = a / b; end
      5'd4: begin if (b == 4'd0) begin q = a; dz = 1'b1; end else q = a % b; end
      5'd5: q = a & b;
      5'd6: q = a | b;
      5'd7: q = a ^ b;
      5'd8: q = a << b;
      5'd9: q = a >> b;
      default: q = 4'd0;
    endcase
    return {dz, v, q[3], (q == 4'd0), c, q};
  endfunction

  assign {alu_f, alu_q} = alu_fn(alu_a, alu_b, alu_ctrl);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".step"}, 32'(step), 32'(m_st));
    check_eq({tag, ".alu_a"}, 32'(alu_a), 32'(m_a));
    check_eq({tag, ".alu_b"}, 32'(alu_b), 32'(m_b));
    check_eq({tag, ".alu_ctrl"}, 32'(alu_ctrl), 32'(m_ctrl));
    check_eq({tag, ".res_q"}, 32'(res_q), 32'(m_q));
    check_eq({tag, ".res_f"}, 32'(res_f), 32'(m_f));
    check_eq({tag, ".err"}, 32'(err), 32'(m_err));
    check_eq({tag, ".done"}, 32'(done), 32'(m_done));
  endtask

  task automatic model_reset();
    m_st = 0; m_a = 4'd0; m_b = 4'd0; m_ctrl = 5'd0; m_q = 4'd0; m_f = 5'd0; m_err = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_load(input logic [3:0] s, input logic [4:0] o);
    case (m_st)
      0: begin m_a = s; m_st = 1; end
      1: begin m_b = s; m_st = 2; end
      2: begin
        if (o <= 5'd9) begin
          m_ctrl = o; m_err = 1'b0; {m_f, m_q} = alu_fn(m_a, m_b, o); m_done = 1'b1; m_st = 4;
        end else begin
          m_err = 1'b1;
        end
      end
      4: begin m_done = 1'b0; m_st = 0; end
      default: m_st = 0;
    endcase
  endtask

  task automatic model_clr();
    m_st = 0; m_done = 1'b0; m_err = 1'b0;
  endtask

  // one button action, started and finished on a falling edge
  task automatic press(input logic ld, input logic cl, input logic [3:0] s, input logic [4:0] o, input int hold);
    sw = s; op_sw = o; load_btn = ld; clr_btn = cl;
    repeat (hold) @(negedge clk);
    load_btn = 1'b0; clr_btn = 1'b0;
    repeat (4) @(negedge clk);
    if (cl) model_clr();
    else if (ld) model_load(s, o);
  endtask

  initial begin
    int cnt;
    logic [3:0] s;
    logic [4:0] o;
    int r;
    rst_n = 1'b0; sw = 4'd0; op_sw = 5'd0; load_btn = 1'b0; clr_btn = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset_held");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_all("reset");

    // basic add with latency checks
    sw = 4'd3; load_btn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1; cnt++;
      if (alu_a == 4'd3) break;
    end
    check_eq("load_latency_ok", 32'((cnt >= 3) && (cnt <= 4)), 32'd1);
    @(negedge clk); load_btn = 1'b0;
    repeat (4) @(negedge clk);
    model_load(4'd3, 5'd0);
    press(1'b1, 1'b0, 4'd5, 5'd0, 5);
    check_all("add_b");
    op_sw = 5'd0; load_btn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (step != 3'd2) break;
    end
    check_eq("add_exec_step", 32'(step), 32'd3);
    check_eq("add_exec_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    check_eq("add_show_step", 32'(step), 32'd4);
    check_eq("add_show_res", 32'(res_q), 32'd8);
    check_eq("add_show_carry", 32'(res_f[0]), 32'd0);
    check_eq("add_show_done", 32'(done), 32'd1);
    @(negedge clk); load_btn = 1'b0;
    repeat (4) @(negedge clk);
    model_load(4'd0, 5'd0);
    check_all("add");

    // held button: exactly one capture
    press(1'b1, 1'b0, 4'd0, 5'd0, 4);
    press(1'b1, 1'b0, 4'd7, 5'd0, 20);
    check_all("held");
    check_eq("held_step", 32'(step), 32'd1);

    // invalid then valid opcode
    press(1'b0, 1'b1, 4'd0, 5'd0, 4);
    press(1'b1, 1'b0, 4'd2, 5'd0, 4);
    press(1'b1, 1'b0, 4'd1, 5'd0, 4);
    press(1'b1, 1'b0, 4'd0, 5'd12, 4);
    check_all("invalid_op");
    check_eq("invalid_err", 32'(err), 32'd1);
    press(1'b1, 1'b0, 4'd0, 5'd1, 4);
    check_all("valid_after_invalid");
    check_eq("sub_res", 32'(res_q), 32'd1);

    // abort has priority over a simultaneous load
    press(1'b1, 1'b0, 4'd0, 5'd0, 4);
    press(1'b1, 1'b0, 4'd9, 5'd0, 4);
    press(1'b1, 1'b0, 4'd4, 5'd0, 4);
    press(1'b1, 1'b0, 4'd0, 5'd13, 4);
    press(1'b1, 1'b1, 4'd0, 5'd2, 4);
    check_all("abort");
    check_eq("abort_ctrl", 32'(alu_ctrl), 32'd1);

    // wrap-around add
    press(1'b1, 1'b0, 4'd15, 5'd0, 4);
    press(1'b1, 1'b0, 4'd1, 5'd0, 4);
    press(1'b1, 1'b0, 4'd0, 5'd0, 4);
    check_all("wrap");
    check_eq("wrap_res", 32'(res_q), 32'd0);
    check_eq("wrap_flags", 32'(res_f), 32'h03);

    // randomised sequence
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 11);
      s = 4'($urandom);
      o = 5'($urandom_range(0, 13));
      if (r == 0) press(1'b0, 1'b1, s, o, $urandom_range(3, 6));
      else if (r == 1) press(1'b1, 1'b1, s, o, $urandom_range(3, 6));
      else press(1'b1, 1'b0, s, o, $urandom_range(3, 8));
      check_all("rand");
    end

    // async reset while showing a result, button held through release
    press(1'b0, 1'b1, 4'd0, 5'd0, 4);
    press(1'b1, 1'b0, 4'd6, 5'd0, 4);
    press(1'b1, 1'b0, 4'd3, 5'd0, 4);
    press(1'b1, 1'b0, 4'd0, 5'd2, 4);
    check_all("pre_reset_show");
    sw = 4'hA; load_btn = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_all("held_through_reset");
    load_btn = 1'b0;
    repeat (4) @(negedge clk);
    press(1'b1, 1'b0, 4'hA, 5'd0, 4);
    check_all("after_reset_press");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
